// File: rtl/mem_arbiter.sv
// Two-requester (instruction fetch / data) arbiter onto a single-outstanding memory bus.
// Optional `define ROUND_ROBIN_EN alternates grants on conflict; default build gives data priority.
module mem_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  // instruction side (read-only, word size)
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,
  // data side
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,
  // bus side
  output logic              bus_req,
  output logic              bus_wr,
  output logic [1:0]        bus_size,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_addr_ok,
  input  logic              bus_data_ok,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              arb_busy
);

  typedef enum logic [1:0] {
    StIdle,
    StAddr,
    StWait
  } state_e;

  state_e              r_state;
  state_e              w_state_d;
  logic                r_wr;
  logic [1:0]          r_size;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_owner_data;
  logic                w_grant_inst;
  logic                w_grant_data;
  logic                w_prefer_data;
  logic                w_done;

`ifdef ROUND_ROBIN_EN
  // Remembers who won the previous grant; 0 = inst, which makes the first conflict go to data.
  logic r_last_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_data <= 1'b0;
    end else if (w_grant_inst || w_grant_data) begin
      r_last_data <= w_grant_data;
    end
  end

  assign w_prefer_data = ~r_last_data;
`else
  assign w_prefer_data = 1'b1;
`endif

  // Grants only exist in IDLE and never while reset is asserted.
  always_comb begin
    w_grant_data = 1'b0;
    w_grant_inst = 1'b0;
    if ((r_state == StIdle) && !rst) begin
      if (data_req && (!inst_req || w_prefer_data)) begin
        w_grant_data = 1'b1;
      end else if (inst_req) begin
        w_grant_inst = 1'b1;
      end
    end
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle: if (w_grant_inst || w_grant_data) w_state_d = StAddr;
      StAddr: if (bus_addr_ok) w_state_d = StWait;
      StWait: if (bus_data_ok) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr         <= 1'b0;
      r_size       <= 2'b00;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_owner_data <= 1'b0;
    end else if (w_grant_data) begin
      r_wr         <= data_wr;
      r_size       <= data_size;
      r_addr       <= data_addr;
      r_wdata      <= data_wdata;
      r_owner_data <= 1'b1;
    end else if (w_grant_inst) begin
      r_wr         <= 1'b0;
      r_size       <= 2'b10;
      r_addr       <= inst_addr;
      r_wdata      <= '0;
      r_owner_data <= 1'b0;
    end
  end

  assign w_done       = (r_state == StWait) && bus_data_ok && !rst;

  assign inst_addr_ok = w_grant_inst;
  assign data_addr_ok = w_grant_data;
  assign inst_data_ok = w_done && !r_owner_data;
  assign data_data_ok = w_done && r_owner_data;
  assign inst_rdata   = bus_rdata;
  assign data_rdata   = bus_rdata;

  assign bus_req      = (r_state == StAddr) && !rst;
  assign bus_wr       = r_wr;
  assign bus_size     = r_size;
  assign bus_addr     = r_addr;
  assign bus_wdata    = r_wdata;
  assign arb_busy     = (r_state != StIdle) && !rst;

  a_addr_ok_idle: assert property (@(posedge clk) (inst_addr_ok || data_addr_ok) |-> (r_state == StIdle));
  a_one_grant:    assert property (@(posedge clk) !(inst_addr_ok && data_addr_ok));
  a_one_done:     assert property (@(posedge clk) !(inst_data_ok && data_data_ok));

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: width of all address ports.
REQ-002 SHALL have parameter DATA_W, default 32: width of all read/write data ports.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have inst-side ports inst_req in 1, inst_addr in ADDR_W, inst_addr_ok out 1, inst_data_ok out 1, inst_rdata out DATA_W; fetch is read-only, word size.
REQ-006 SHALL have data-side ports data_req in 1, data_wr in 1, data_size in 2, data_addr in ADDR_W, data_wdata in DATA_W, data_addr_ok out 1, data_data_ok out 1, data_rdata out DATA_W.
REQ-007 SHALL have bus-side ports bus_req out 1, bus_wr out 1, bus_size out 2, bus_addr out ADDR_W, bus_wdata out DATA_W, bus_addr_ok in 1, bus_data_ok in 1, bus_rdata in DATA_W.
REQ-008 SHALL have port arb_busy  output  1  high whenever state is not IDLE.

Function
REQ-009 SHALL implement FSM states IDLE, ADDR, WAIT; at most one bus transaction outstanding.
REQ-010 IDLE: if data_req or inst_req is high, SHALL select a grantee, assert that requester's addr_ok combinationally in the same cycle, latch its wr/size/addr/wdata and owner id, and go to ADDR.
REQ-011 Inst grant SHALL latch wr=0, size=2'b10.
REQ-012 Without ROUND_ROBIN_EN, simultaneous inst_req and data_req SHALL grant data.
REQ-013 ADDR: bus_req SHALL be 1 with latched wr/size/addr/wdata held stable until the cycle bus_addr_ok=1, then go to WAIT.
REQ-014 WAIT: on bus_data_ok=1, SHALL assert owner's data_ok combinationally that cycle, pass bus_rdata to owner's rdata, and return to IDLE.
REQ-015 inst_rdata and data_rdata SHALL equal bus_rdata at all times; only data_ok qualifies validity.
REQ-016 bus_data_ok in IDLE or ADDR SHALL be ignored (no data_ok output, no state change).
REQ-017 addr_ok SHALL never be asserted outside IDLE; requesters hold req until addr_ok.
REQ-018 Non-owner's data_ok SHALL stay 0.
REQ-019 Minimum latency: req at cycle T, bus_req at T+1, owner data_ok at T+2 when the bus answers with addr_ok at T+1 and data_ok at T+2.
REQ-020 Back-to-back: return to IDLE at T+2 allows a new grant (addr_ok) at T+3.

Reset
REQ-021 On rst=1 at a clock edge, state SHALL become IDLE and latched wr/size/addr/wdata SHALL clear to 0 regardless of current state.
REQ-022 During and after reset: bus_req=0, inst_addr_ok=0, data_addr_ok=0, inst_data_ok=0, data_data_ok=0, arb_busy=0; addr_ok outputs forced to 0 while rst=1.
REQ-023 Reset mid-transaction SHALL abandon it; a subsequent stray bus_data_ok in IDLE is ignored per REQ-016.
REQ-024 last_grant register SHALL reset to inst.

Configuration
REQ-025 Macro ROUND_ROBIN_EN, when defined, SHALL grant on conflict the requester not in last_grant, with last_grant updated at every grant; first conflict after reset grants data.
REQ-026 Without ROUND_ROBIN_EN, fixed data priority per REQ-012 SHALL apply and last_grant SHALL not be implemented.

Verification
REQ-027 inst_req=1, inst_addr=0xBFC00000, bus addr_ok immediate, data_ok next cycle with rdata=0x3C1D0001 -> inst_addr_ok T, bus_req/addr 0xBFC00000 wr=0 size=2 at T+1, inst_data_ok=1 and inst_rdata=0x3C1D0001 at T+2.
REQ-028 data_req=1 wr=1 size=2'b00 addr=0x80001003 wdata=0x000000AB, bus_addr_ok delayed 3 cycles -> bus_req held stable 4 cycles with identical fields, data_data_ok after bus_data_ok, inst_data_ok=0 throughout.
REQ-029 inst_req and data_req both high continuously for 4 grants -> without macro: data,data,data,data; with ROUND_ROBIN_EN: data,inst,data,inst.
REQ-030 rst=1 pulsed during WAIT, then bus_data_ok=1 in IDLE -> no data_ok on either side, arb_busy=0, next request granted normally.
REQ-031 bus_data_ok=1 asserted spuriously in ADDR with bus_addr_ok=0 -> no data_ok output, state stays ADDR.
